conv_controller: RTL and testbench

Sequencing FSM for the convolution datapath. It loads the filter buffers and the image tile from memory, then steps slice / multiply-accumulate / store / write-back per output column, and advances the image offset per tile row until all rows are done. The datapath's counters and buffers perform the actual work; this block only drives their enables and selects and consumes their carry-outs.

---
 rtl/conv_controller_pkg.sv | 103 ++++++++++
 rtl/conv_controller_load_beat_timer.sv | 28 ++
 rtl/conv_controller.sv | 127 ++++++++++++
 tb/tb_conv_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_controller_pkg.sv
// Shared types and encodings for the convolution sequencer.
// Holds the state/phase enums, the select encodings and the state-to-control decode.
package conv_controller_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_FILT,
        S_LD_IMG,
        S_SLICE,
        S_MAC,
        S_STORE,
        S_WRITE,
        S_NEXT_ROW,
        S_DONE
    } state_t;

    typedef enum logic {
        PH_ADDR,
        PH_WR
    } phase_t;

    localparam logic [1:0] OFS_FILT = 2'd0;
    localparam logic [1:0] OFS_IMG  = 2'd1;
    localparam logic [1:0] OFS_OUT  = 2'd2;

    localparam logic ADR_FILT = 1'b0;
    localparam logic ADR_IMG  = 1'b1;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       inc_en;
        logic       adr_sel;
        logic [1:0] mem_offset_sel;
        logic       cntr4_filter_en;
        logic       filter_wr_en;
        logic       cntr16_img_en;
        logic       img_wr_en;
        logic       row_cntr_en;
        logic       img_slice_en;
        logic       col_cntr_en;
        logic       cntr16_en;
        logic       acc_en;
        logic       rst_acc;
        logic       res_buffer_en;
        logic       cntr_reg4_en;
        logic       rst_res_reg;
        logic       mem_en;
        logic       wr_file;
        logic       cntr43_en;
        logic       cntr13_en;
    } ctrl_t;

    // Moore decode: every field not named for a state stays 0, including unused selects.
    function automatic ctrl_t ctrl_decode(input state_t s, input phase_t p);
        ctrl_t c;
        c      = '0;
        c.busy = (s != S_IDLE);
        case (s)
            S_LD_FILT: begin
                c.adr_sel         = ADR_FILT;
                c.mem_offset_sel  = OFS_FILT;
                c.filter_wr_en    = (p == PH_WR);
                c.cntr4_filter_en = (p == PH_WR);
            end
            S_LD_IMG: begin
                c.adr_sel        = ADR_IMG;
                c.mem_offset_sel = OFS_IMG;
                c.img_wr_en      = (p == PH_WR);
                c.cntr16_img_en  = (p == PH_WR);
            end
            S_SLICE: begin
                c.img_slice_en = 1'b1;
                c.row_cntr_en  = 1'b1;
            end
            S_MAC: begin
                c.cntr16_en = 1'b1;
                c.acc_en    = 1'b1;
            end
            S_STORE: begin
                c.res_buffer_en = 1'b1;
                c.cntr_reg4_en  = 1'b1;
                c.col_cntr_en   = 1'b1;
                c.rst_acc       = 1'b1;
            end
            S_WRITE: begin
                c.mem_offset_sel = OFS_OUT;
                c.mem_en         = 1'b1;
                c.wr_file        = 1'b1;
                c.cntr43_en      = 1'b1;
                c.rst_res_reg    = 1'b1;
            end
            S_NEXT_ROW: begin
                c.inc_en    = 1'b1;
                c.cntr13_en = 1'b1;
            end
            S_DONE: c.done = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/conv_controller_load_beat_timer.sv
// Counts the address phase of a memory load beat.
// Latency: expire rises in the MEM_LAT-th consecutive cycle of run; no backpressure.
// Counter idles at 0 whenever run is low, so each beat starts a fresh count.
module load_beat_timer #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expire
);
    localparam int W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [W-1:0] LAST = W'(MEM_LAT - 1);

    logic [W-1:0] cnt;

    assign expire = run && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/conv_controller.sv
// Sequencing FSM for the convolution datapath: filter load, image load, slice/MAC/store/write per column.
// Latency: outputs registered from next state; a load beat is MEM_LAT+1 cycles.
// Backpressure: none; progress is paced only by the datapath carry-outs, start is ignored while busy.
module conv_controller
    import conv_controller_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       co_cntr4_filter,
    input  logic       co_cntr_filters,
    input  logic       co_cntr16_img,
    input  logic       co_row_cntr,
    input  logic       co_cntr16,
    input  logic       co_cntr_reg4,
    input  logic       co_col_cntr,
    input  logic       co_cntr13,
    output logic       busy,
    output logic       done,
    output logic       inc_ld,
    output logic       inc_en,
    output logic       adr_sel,
    output logic [1:0] mem_offset_sel,
    output logic       cntr4_filter_en,
    output logic       cntr_filters_en,
    output logic       filter_wr_en,
    output logic       cntr16_img_en,
    output logic       img_wr_en,
    output logic       row_cntr_en,
    output logic       img_slice_en,
    output logic       col_cntr_en,
    output logic       cntr16_en,
    output logic       acc_en,
    output logic       rst_acc,
    output logic       res_buffer_en,
    output logic       cntr_reg4_en,
    output logic       rst_res_reg,
    output logic       mem_en,
    output logic       wr_file,
    output logic       cntr43_en,
    output logic       cntr13_en
);
    state_t state, state_nxt;
    phase_t phase, phase_nxt;
    ctrl_t  ctrl;
    logic   last_col;
    logic   inc_ld_q;
    logic   addr_run;
    logic   beat_rdy;

    assign addr_run = (phase == PH_ADDR) && ((state == S_LD_FILT) || (state == S_LD_IMG));

    load_beat_timer #(.MEM_LAT(MEM_LAT)) u_load_beat_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (addr_run),
        .expire (beat_rdy)
    );

    always_comb begin
        state_nxt = state;
        phase_nxt = PH_ADDR;
        case (state)
            S_IDLE:     if (start) state_nxt = S_LD_FILT;
            S_LD_FILT: begin
                if (phase == PH_ADDR) phase_nxt = beat_rdy ? PH_WR : PH_ADDR;
                else if (co_cntr4_filter && co_cntr_filters) state_nxt = S_LD_IMG;
            end
            S_LD_IMG: begin
                if (phase == PH_ADDR) phase_nxt = beat_rdy ? PH_WR : PH_ADDR;
                else if (co_cntr16_img) state_nxt = S_SLICE;
            end
            S_SLICE:    if (co_row_cntr) state_nxt = S_MAC;
            S_MAC:      if (co_cntr16) state_nxt = S_STORE;
            S_STORE:    state_nxt = (co_cntr_reg4 || co_col_cntr) ? S_WRITE : S_SLICE;
            S_WRITE:    state_nxt = last_col ? S_NEXT_ROW : S_SLICE;
            // Filters stay resident across rows; only the image tile is reloaded.
            S_NEXT_ROW: state_nxt = co_cntr13 ? S_DONE : S_LD_IMG;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            phase    <= PH_ADDR;
            last_col <= 1'b0;
            ctrl     <= '0;
            inc_ld_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            ctrl     <= ctrl_decode(state_nxt, phase_nxt);
            inc_ld_q <= (state == S_IDLE) && start;
            if (state == S_STORE)         last_col <= co_col_cntr;
            else if (state == S_NEXT_ROW) last_col <= 1'b0;
        end
    end

    assign busy            = ctrl.busy;
    assign done            = ctrl.done;
    assign inc_ld          = inc_ld_q;
    assign inc_en          = ctrl.inc_en;
    assign adr_sel         = ctrl.adr_sel;
    assign mem_offset_sel  = ctrl.mem_offset_sel;
    assign cntr4_filter_en = ctrl.cntr4_filter_en;
    assign cntr_filters_en = ctrl.filter_wr_en & co_cntr4_filter;
    assign filter_wr_en    = ctrl.filter_wr_en;
    assign cntr16_img_en   = ctrl.cntr16_img_en;
    assign img_wr_en       = ctrl.img_wr_en;
    assign row_cntr_en     = ctrl.row_cntr_en;
    assign img_slice_en    = ctrl.img_slice_en;
    assign col_cntr_en     = ctrl.col_cntr_en;
    assign cntr16_en       = ctrl.cntr16_en;
    assign acc_en          = ctrl.acc_en;
    assign rst_acc         = ctrl.rst_acc;
    assign res_buffer_en   = ctrl.res_buffer_en;
    assign cntr_reg4_en    = ctrl.cntr_reg4_en;
    assign rst_res_reg     = ctrl.rst_res_reg;
    assign mem_en          = ctrl.mem_en;
    assign wr_file         = ctrl.wr_file;
    assign cntr43_en       = ctrl.cntr43_en;
    assign cntr13_en       = ctrl.cntr13_en;
endmodule

// File: tb/tb_conv_controller.sv
// Directed bench for conv_controller: MEM_LAT=1 instance driven by a counter model, MEM_LAT=3 instance for beat spacing.
module tb_conv_controller;
    localparam int B_BUSY = 0,  B_DONE = 1,  B_INCLD = 2,  B_INCEN = 3,  B_ADR = 4,  B_OFS = 5;
    localparam int B_C4F = 7,   B_CF = 8,    B_FWE = 9,    B_C16I = 10,  B_IWE = 11, B_ROW = 12;
    localparam int B_SLICE = 13, B_COL = 14, B_C16 = 15,   B_ACC = 16,   B_RSTACC = 17, B_RES = 18;
    localparam int B_REG4 = 19, B_RSTRES = 20, B_MEMEN = 21, B_WRF = 22, B_C43 = 23, B_C13 = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start3 = 1'b0;
    logic        force13 = 1'b1;
    logic [24:0] o1, o3;
    logic        co_c4f, co_cf, co_c16i, co_row, co_c16, co_reg4, co_col, co_c13;
    logic [1:0]  c4f, crow, creg4, cf;
    logic [3:0]  c16i, c16, ccol, c13;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    conv_controller #(.MEM_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .co_cntr4_filter(co_c4f), .co_cntr_filters(co_cf), .co_cntr16_img(co_c16i), .co_row_cntr(co_row),
        .co_cntr16(co_c16), .co_cntr_reg4(co_reg4), .co_col_cntr(co_col), .co_cntr13(co_c13),
        .busy(o1[B_BUSY]), .done(o1[B_DONE]), .inc_ld(o1[B_INCLD]), .inc_en(o1[B_INCEN]),
        .adr_sel(o1[B_ADR]), .mem_offset_sel(o1[B_OFS+:2]),
        .cntr4_filter_en(o1[B_C4F]), .cntr_filters_en(o1[B_CF]), .filter_wr_en(o1[B_FWE]),
        .cntr16_img_en(o1[B_C16I]), .img_wr_en(o1[B_IWE]),
        .row_cntr_en(o1[B_ROW]), .img_slice_en(o1[B_SLICE]), .col_cntr_en(o1[B_COL]),
        .cntr16_en(o1[B_C16]), .acc_en(o1[B_ACC]), .rst_acc(o1[B_RSTACC]),
        .res_buffer_en(o1[B_RES]), .cntr_reg4_en(o1[B_REG4]), .rst_res_reg(o1[B_RSTRES]),
        .mem_en(o1[B_MEMEN]), .wr_file(o1[B_WRF]), .cntr43_en(o1[B_C43]), .cntr13_en(o1[B_C13])
    );

    conv_controller #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .co_cntr4_filter(1'b0), .co_cntr_filters(1'b0), .co_cntr16_img(1'b0), .co_row_cntr(1'b0),
        .co_cntr16(1'b0), .co_cntr_reg4(1'b0), .co_col_cntr(1'b0), .co_cntr13(1'b0),
        .busy(o3[B_BUSY]), .done(o3[B_DONE]), .inc_ld(o3[B_INCLD]), .inc_en(o3[B_INCEN]),
        .adr_sel(o3[B_ADR]), .mem_offset_sel(o3[B_OFS+:2]),
        .cntr4_filter_en(o3[B_C4F]), .cntr_filters_en(o3[B_CF]), .filter_wr_en(o3[B_FWE]),
        .cntr16_img_en(o3[B_C16I]), .img_wr_en(o3[B_IWE]),
        .row_cntr_en(o3[B_ROW]), .img_slice_en(o3[B_SLICE]), .col_cntr_en(o3[B_COL]),
        .cntr16_en(o3[B_C16]), .acc_en(o3[B_ACC]), .rst_acc(o3[B_RSTACC]),
        .res_buffer_en(o3[B_RES]), .cntr_reg4_en(o3[B_REG4]), .rst_res_reg(o3[B_RSTRES]),
        .mem_en(o3[B_MEMEN]), .wr_file(o3[B_WRF]), .cntr43_en(o3[B_C43]), .cntr13_en(o3[B_C13])
    );

    // Datapath counter model: carry-out is high at the terminal value while enabled.
    assign co_c4f  = o1[B_C4F]  && (c4f == 2'd3);
    assign co_cf   = o1[B_CF]   && (cf == 2'd2);
    assign co_c16i = o1[B_C16I] && (c16i == 4'd15);
    assign co_row  = o1[B_ROW]  && (crow == 2'd3);
    assign co_c16  = o1[B_C16]  && (c16 == 4'd15);
    assign co_reg4 = o1[B_REG4] && (creg4 == 2'd3);
    assign co_col  = o1[B_COL]  && (ccol == 4'd12);
    assign co_c13  = o1[B_C13]  && ((c13 == 4'd12) || force13);

    always @(posedge clk) begin
        if (rst) begin
            c4f <= '0; cf <= '0; c16i <= '0; crow <= '0; c16 <= '0; creg4 <= '0; ccol <= '0; c13 <= '0;
        end else begin
            if (o1[B_C4F])  c4f   <= c4f + 2'd1;
            if (o1[B_CF])   cf    <= co_cf ? 2'd0 : cf + 2'd1;
            if (o1[B_C16I]) c16i  <= c16i + 4'd1;
            if (o1[B_ROW])  crow  <= crow + 2'd1;
            if (o1[B_C16])  c16   <= c16 + 4'd1;
            if (o1[B_REG4]) creg4 <= creg4 + 2'd1;
            if (o1[B_COL])  ccol  <= co_col ? 4'd0 : ccol + 4'd1;
            if (o1[B_C13])  c13   <= co_c13 ? 4'd0 : c13 + 4'd1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int   stores, writes, slices, macs, cyc, bad_ofs, k;
        int   wr_col[4];
        logic found;

        tick; tick;
        chk("reset_outputs", o1, 0);
        chk("reset_outputs_lat3", o3, 0);
        rst = 1'b0;
        tick;
        chk("idle_no_start", o1, 0);

        // Run 1: full filter load, image load, one row, forced last row.
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_busy", o1[B_BUSY], 1);
        chk("start_inc_ld", o1[B_INCLD], 1);
        chk("start_addr_phase", {o1[B_FWE], o1[B_ADR], o1[B_OFS+:2]}, 0);
        for (int b = 0; b < 12; b++) begin
            tick;
            chk("filt_wr", {o1[B_FWE], o1[B_C4F], o1[B_ADR], o1[B_OFS+:2], o1[B_INCLD]}, 6'b110000);
            chk("filt_cntr_filters_en", o1[B_CF], (b % 4 == 3));
            tick;
            if (b < 11) chk("filt_addr_gap", o1[B_FWE], 0);
        end
        chk("img_sel", {o1[B_ADR], o1[B_OFS+:2], o1[B_IWE]}, 4'b1010);
        for (int b = 0; b < 16; b++) begin
            tick;
            chk("img_wr", {o1[B_IWE], o1[B_C16I], o1[B_ADR], o1[B_OFS+:2]}, 5'b11101);
            tick;
            if (b < 15) chk("img_addr_gap", o1[B_IWE], 0);
        end
        chk("slice_after_img", {o1[B_SLICE], o1[B_ROW]}, 2'b11);

        start = 1'b1;
        stores = 0; writes = 0; slices = 0; macs = 0; bad_ofs = 0; cyc = 0; found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (o1[B_INCEN]) begin
                found = 1'b1;
            end else begin
                if (o1[B_SLICE]) slices++;
                if (o1[B_ACC])   macs++;
                if (o1[B_RES])   stores++;
                if (o1[B_MEMEN]) begin
                    if (writes < 4) wr_col[writes] = stores;
                    writes++;
                    if (o1[B_OFS+:2] !== 2'd2) bad_ofs++;
                end
                cyc++;
                tick;
                start = 1'b0;
            end
        end
        chk("row_reached_next_row", found, 1);
        chk("row_cycles", cyc, 277);
        chk("row_slices", slices, 52);
        chk("row_macs", macs, 208);
        chk("row_stores", stores, 13);
        chk("row_writes", writes, 4);
        chk("write_col_0", wr_col[0], 4);
        chk("write_col_1", wr_col[1], 8);
        chk("write_col_2", wr_col[2], 12);
        chk("write_col_3", wr_col[3], 13);
        chk("write_ofs_out", bad_ofs, 0);
        chk("next_row_vec", o1, 25'h1000009);
        tick;
        chk("done_vec", o1, 25'h3);
        tick;
        chk("after_done_idle", o1, 0);
        tick; tick; tick;
        chk("start_not_queued", o1[B_BUSY], 0);

        // Run 2: reset in the middle of MAC.
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("run2_first_filt_wr", o1[B_FWE], 1);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (o1[B_ACC]) found = 1'b1;
            else tick;
        end
        chk("run2_reach_mac", found, 1);
        tick; tick;
        rst = 1'b1;
        tick;
        chk("rst_mid_mac", o1, 0);
        rst = 1'b0;
        tick;
        chk("rst_stays_idle", o1, 0);

        // Run 3: full filter load replays after the abort.
        start = 1'b1;
        tick;
        start = 1'b0;
        k = 0; found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick;
            if (o1[B_IWE]) found = 1'b1;
            else if (o1[B_FWE]) k++;
        end
        chk("replay_reach_img", found, 1);
        chk("replay_filt_count", k, 12);

        // MEM_LAT=3: four-cycle beats, write enable in every fourth cycle.
        start3 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick;
            start3 = 1'b0;
            chk("lat3_vec", o3, (i == 1) ? 32'h5 : ((i % 4 == 0) ? 32'h281 : 32'h1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
